dmem_arbiter: RTL and testbench

//   Shares the single-port, word-aligned data memory (dmem) between two requesters:

---
 rtl/dmem_arbiter_if.sv | 16 +
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one dmem_arbiter port.
// Handshake: the master raises req with we/addr/wdata and holds them until it sees ack;
// ack is a one-cycle pulse with err/rdata valid only in that cycle; the master may drop
// req at the edge ending the ack cycle or keep it high (with a new payload) to go again.
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic        err;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, input ack, err, rdata);
   modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port word-aligned dmem: IDLE -> ACC -> RESP,
// one access per grant, round-robin or fixed priority, out-of-range accesses flagged.
module dmem_arbiter #(
   parameter int DEPTH      = 64,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  p0,
   dmem_arbiter_if.slave  p1,
   output logic           mem_we,
   output logic [31:0]    mem_a,
   output logic [31:0]    mem_wd,
   input  logic [31:0]    mem_rd,
   output logic           busy,
   output logic [1:0]     dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic        last_grant;
   logic        winner;
   logic        pick1;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_we;
   logic        acc_in_range;

   function automatic logic in_range(input logic [31:0] a);
      return a[31:2] < 30'(DEPTH);
   endfunction

   // Tie-break favours the port that was not granted last unless priority is fixed.
   always_comb begin
      pick1 = p1.req;
      if (p0.req && p1.req) begin
         pick1 = FIXED_PRIO ? 1'b0 : ~last_grant;
      end
   end

   assign sel_addr     = pick1 ? p1.addr  : p0.addr;
   assign sel_wdata    = pick1 ? p1.wdata : p0.wdata;
   assign sel_we       = pick1 ? p1.we    : p0.we;
   assign acc_in_range = in_range(mem_a);
   assign dbg_state    = state;

   // mem_a/mem_wd double as the latched request while in ACC and read zero elsewhere.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         winner     <= 1'b0;
         mem_we     <= 1'b0;
         mem_a      <= '0;
         mem_wd     <= '0;
         busy       <= 1'b0;
         p0.ack     <= 1'b0;
         p0.err     <= 1'b0;
         p0.rdata   <= '0;
         p1.ack     <= 1'b0;
         p1.err     <= 1'b0;
         p1.rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (p0.req || p1.req) begin
                  winner <= pick1;
                  mem_a  <= sel_addr;
                  mem_wd <= sel_wdata;
                  mem_we <= sel_we && in_range(sel_addr);
                  busy   <= 1'b1;
                  state  <= ACC;
               end
            end
            ACC: begin
               last_grant <= winner;
               mem_we     <= 1'b0;
               mem_a      <= '0;
               mem_wd     <= '0;
               p0.ack     <= ~winner;
               p0.err     <= ~winner & ~acc_in_range;
               p0.rdata   <= (~winner & acc_in_range) ? mem_rd : 32'd0;
               p1.ack     <= winner;
               p1.err     <= winner & ~acc_in_range;
               p1.rdata   <= (winner & acc_in_range) ? mem_rd : 32'd0;
               state      <= RESP;
            end
            RESP: begin
               p0.ack   <= 1'b0;
               p0.err   <= 1'b0;
               p0.rdata <= '0;
               p1.ack   <= 1'b0;
               p1.err   <= 1'b0;
               p1.rdata <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random rounds against a transaction-level
// model (word array + "serve the port not served last" ordering) with a response scoreboard.
module tb_dmem_arbiter;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   dmem_arbiter_if p0_if ();
   dmem_arbiter_if p1_if ();
   dmem_arbiter_if f0_if ();
   dmem_arbiter_if f1_if ();

   logic        req [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        ack [2];
   logic        err [2];
   logic [31:0] rdata [2];

   assign p0_if.req = req[0];   assign p0_if.we = we[0];
   assign p0_if.addr = addr[0]; assign p0_if.wdata = wdata[0];
   assign p1_if.req = req[1];   assign p1_if.we = we[1];
   assign p1_if.addr = addr[1]; assign p1_if.wdata = wdata[1];
   assign ack[0] = p0_if.ack;   assign err[0] = p0_if.err;   assign rdata[0] = p0_if.rdata;
   assign ack[1] = p1_if.ack;   assign err[1] = p1_if.err;   assign rdata[1] = p1_if.rdata;

   logic        f_req0 = 1'b0;
   logic        f_req1 = 1'b0;
   assign f0_if.req = f_req0;   assign f0_if.we = 1'b0;
   assign f0_if.addr = 32'd0;   assign f0_if.wdata = 32'd0;
   assign f1_if.req = f_req1;   assign f1_if.we = 1'b0;
   assign f1_if.addr = 32'd4;   assign f1_if.wdata = 32'd0;

   logic        mem_we, f_mem_we, busy, f_busy;
   logic [31:0] mem_a, mem_wd, mem_rd, f_mem_a, f_mem_wd;
   logic [1:0]  dbg_state, f_dbg_state;

   dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .reset(reset), .p0(p0_if.slave), .p1(p1_if.slave),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .busy(busy), .dbg_state(dbg_state)
   );

   dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .reset(reset), .p0(f0_if.slave), .p1(f1_if.slave),
      .mem_we(f_mem_we), .mem_a(f_mem_a), .mem_wd(f_mem_wd), .mem_rd(32'd0),
      .busy(f_busy), .dbg_state(f_dbg_state)
   );

   // Environment dmem: out-of-range reads return a poison value the DUT must not pass on.
   logic [31:0] dmem [DEPTH];
   assign mem_rd = (mem_a < 32'(4 * DEPTH)) ? dmem[int'(mem_a >> 2)] : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      if (mem_we && mem_a < 32'(4 * DEPTH)) dmem[int'(mem_a >> 2)] <= mem_wd;
   end

   // Reference model and scoreboard state.
   logic [31:0] ref_mem [DEPTH];
   int          last_srv = 1;
   logic [64:0] pay_q0[$];
   logic [64:0] pay_q1[$];
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   int          exp_port_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] model_access(input logic w, input logic [31:0] a,
                                                input logic [31:0] d);
      logic [32:0] r;
      if (a >= 32'(4 * DEPTH)) begin
         r = {1'b1, 32'd0};
      end else begin
         r = {1'b0, ref_mem[int'(a >> 2)]};
         if (w) ref_mem[int'(a >> 2)] = d;
      end
      return r;
   endfunction

   task automatic expect_txn(input int p, input logic [64:0] t);
      logic [32:0] r;
      r = model_access(t[64], t[63:32], t[31:0]);
      if (p == 0) exp_q0.push_back(r);
      else exp_q1.push_back(r);
      exp_port_q.push_back(p);
      last_srv = p;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      req[0] = 1'b0;
      req[1] = 1'b0;
      f_req0 = 1'b0;
      f_req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      last_srv = 1;
   endtask

   // While our own access is in ACC, scribble over the payload: the latched copy must win.
   task automatic wait_ack(input int p);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
         if (dbg_state == 2'd1 && !req[1 - p] && !ack[p]) begin
            addr[p]  = $urandom;
            wdata[p] = $urandom;
            we[p]    = 1'($urandom_range(0, 1));
         end
      end while (!ack[p] && c < 40);
      chk($sformatf("ack_seen_p%0d", p), 64'(ack[p]), 64'd1);
   endtask

   task automatic run_port(input int p);
      logic [64:0] t;
      int n;
      n = (p == 0) ? pay_q0.size() : pay_q1.size();
      for (int k = 0; k < n; k++) begin
         if (p == 0) t = pay_q0.pop_front();
         else t = pay_q1.pop_front();
         we[p]    = t[64];
         addr[p]  = t[63:32];
         wdata[p] = t[31:0];
         req[p]   = 1'b1;
         wait_ack(p);
         @(posedge clk);
         #1;
      end
      req[p] = 1'b0;
   endtask

   // Both ports start together and re-request back to back; the model serves the port
   // that was not served last whenever both still have work.
   task automatic run_round();
      int i0 = 0;
      int i1 = 0;
      int s;
      while (i0 < pay_q0.size() || i1 < pay_q1.size()) begin
         if (i0 < pay_q0.size() && i1 < pay_q1.size()) s = (last_srv == 1) ? 0 : 1;
         else s = (i0 < pay_q0.size()) ? 0 : 1;
         if (s == 0) begin expect_txn(0, pay_q0[i0]); i0++; end
         else begin expect_txn(1, pay_q1[i1]); i1++; end
      end
      fork
         run_port(0);
         run_port(1);
      join
   endtask

   function automatic logic [64:0] rand_txn();
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(4 * DEPTH, 4 * DEPTH + 4096);
      else a = $urandom_range(0, 4 * DEPTH - 1);
      return {1'($urandom_range(0, 1)), a, 32'($urandom)};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
               chk("ack_expected", 64'(exp_port_q.size() > 0), 64'd1);
               if (exp_port_q.size() > 0) chk("ack_order", 64'(exp_port_q.pop_front()), 64'(p));
               if (p == 0 && exp_q0.size() > 0) chk("p0_resp", 64'({err[0], rdata[0]}), 64'(exp_q0.pop_front()));
               if (p == 1 && exp_q1.size() > 0) chk("p1_resp", 64'({err[1], rdata[1]}), 64'(exp_q1.pop_front()));
            end else begin
               chk($sformatf("p%0d_quiet", p), 64'({err[p], rdata[p]}), 64'd0);
            end
         end
         if (mem_we) chk("mem_we_in_range", 64'(mem_a < 32'(4 * DEPTH)), 64'd1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0, cnt1, c;
      logic got;
      for (int i = 0; i < DEPTH; i++) begin
         dmem[i]    = 32'd0;
         ref_mem[i] = 32'd0;
      end
      req[0] = 1'b0; req[1] = 1'b0; we[0] = 1'b0; we[1] = 1'b0;
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      do_reset();

      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_state", 64'(dbg_state), 64'd0);
      chk("reset_mem_we", 64'(mem_we), 64'd0);
      chk("reset_mem_a", 64'(mem_a), 64'd0);

      // Store 25 to 104: mem_we one cycle after the latch edge, ack one cycle later.
      expect_txn(0, {1'b1, 32'd104, 32'd25});
      we[0] = 1'b1; addr[0] = 32'd104; wdata[0] = 32'd25; req[0] = 1'b1;
      @(negedge clk);
      chk("idle_mem_we", 64'(mem_we), 64'd0);
      @(negedge clk);
      chk("acc_mem_we", 64'(mem_we), 64'd1);
      chk("acc_mem_a", 64'(mem_a), 64'd104);
      chk("acc_mem_wd", 64'(mem_wd), 64'd25);
      chk("acc_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("resp_p0_ack", 64'(ack[0]), 64'd1);
      @(posedge clk);
      #1 req[0] = 1'b0;
      pay_q0.push_back({1'b0, 32'd104, 32'd0});
      run_round();

      // Simultaneous requests after reset, then continuous: p0,p1,p0,p1,p0,p1.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         pay_q0.push_back(rand_txn());
         pay_q1.push_back(rand_txn());
      end
      run_round();

      // Out-of-range store from p1, then word 0 must still read back unchanged.
      pay_q1.push_back({1'b1, 32'd256, 32'hDEAD});
      run_round();
      pay_q0.push_back({1'b0, 32'd0, 32'd0});
      run_round();

      // Unaligned load sees the aligned word.
      pay_q0.push_back({1'b1, 32'h60, 32'h1234_5678});
      run_round();
      pay_q1.push_back({1'b0, 32'h63, 32'd0});
      run_round();

      // Reset in ACC kills the write and the ack.
      pay_q0.push_back({1'b1, 32'd96, 32'h0BAD_0001});
      run_round();
      we[0] = 1'b1; addr[0] = 32'd96; wdata[0] = 32'hCAFE_F00D; req[0] = 1'b1;
      @(posedge clk);
      #2 chk("acc_reset_pre_we", 64'(mem_we), 64'd1);
      reset = 1'b1;
      req[0] = 1'b0;
      #1;
      chk("acc_reset_we_drop", 64'(mem_we), 64'd0);
      chk("acc_reset_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      last_srv = 1;
      pay_q1.push_back({1'b0, 32'd96, 32'd0});
      run_round();

      // Reset in RESP: write already committed, ack suppressed.
      we[1] = 1'b1; addr[1] = 32'd8; wdata[1] = 32'h55; req[1] = 1'b1;
      void'(model_access(1'b1, 32'd8, 32'h55));
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      req[1] = 1'b0;
      #1;
      chk("resp_reset_ack", 64'(ack[1]), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      last_srv = 1;
      pay_q0.push_back({1'b0, 32'd8, 32'd0});
      run_round();

      // Random rounds.
      for (int r = 0; r < 30; r++) begin
         for (int k = $urandom_range(0, 3); k > 0; k--) pay_q0.push_back(rand_txn());
         for (int k = $urandom_range(0, 3); k > 0; k--) pay_q1.push_back(rand_txn());
         run_round();
      end

      // Fixed priority: p1 starves while p0 keeps requesting, then gets served.
      do_reset();
      cnt0 = 0; cnt1 = 0; c = 0; got = 1'b0;
      f_req0 = 1'b1; f_req1 = 1'b1;
      while (cnt0 < 3 && c < 40) begin
         @(negedge clk);
         c++;
         if (f0_if.ack) cnt0++;
         if (f1_if.ack) cnt1++;
      end
      chk("fp_p0_count", 64'(cnt0), 64'd3);
      chk("fp_p1_starved", 64'(cnt1), 64'd0);
      @(posedge clk);
      #1 f_req0 = 1'b0;
      c = 0;
      while (!got && c < 20) begin
         @(negedge clk);
         c++;
         if (f1_if.ack) got = 1'b1;
         if (f0_if.ack) cnt0++;
      end
      chk("fp_p1_served", 64'(got), 64'd1);
      chk("fp_p0_after_drop", 64'(cnt0), 64'd3);
      @(posedge clk);
      #1 f_req1 = 1'b0;

      repeat (5) @(posedge clk);
      chk("exp_queue_drained", 64'(exp_port_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
